// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mem_arbiter
// Purpose : two-master round-robin arbiter in front of a 1-cycle-read RAM.
//           Define MEM_ARB_FIXED_PRIORITY_EN for fixed m0-wins-ties priority.
// Revision: 1.0
// ============================================================================
module mem_arbiter #(
  parameter int MEM_WORDS = 1536
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wmask,
  input  logic        m0_rstrb,
  output logic [31:0] m0_rdata,
  output logic        m0_ack,
  output logic        m0_err,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wmask,
  input  logic        m1_rstrb,
  output logic [31:0] m1_rdata,
  output logic        m1_ack,
  output logic        m1_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  output logic        mem_rstrb,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0]  S_IDLE     = 2'd0;
  localparam logic [1:0]  S_ISSUE    = 2'd1;
  localparam logic [1:0]  S_RESP     = 2'd2;
  localparam logic [29:0] C_WORD_LIM = 30'(MEM_WORDS);

  logic [1:0]  state_q, state_d;
  logic        gnt_q, gnt_d;
  logic        oor_q, oor_d;
  logic        rstrb_q, rstrb_d;
  logic [3:0]  wmask_q, wmask_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;

  logic        req0, req1, sel;
  logic [31:0] sel_addr;
  logic        in_issue, in_resp;
  logic [31:0] resp_data;

  assign req0 = m0_rstrb | (|m0_wmask);
  assign req1 = m1_rstrb | (|m1_wmask);

`ifdef MEM_ARB_FIXED_PRIORITY_EN
  assign sel = ~req0 & req1;
`else
  logic last_q, last_d;
  // On a tie the master that did not win last time is served.
  assign sel = (req0 & req1) ? ~last_q : req1;
`endif

  assign sel_addr = sel ? m1_addr : m0_addr;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    oor_d   = oor_q;
    rstrb_d = rstrb_q;
    wmask_d = wmask_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
`ifndef MEM_ARB_FIXED_PRIORITY_EN
    last_d  = last_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req0 | req1) begin
          state_d = S_ISSUE;
          gnt_d   = sel;
          addr_d  = sel_addr;
          wdata_d = sel ? m1_wdata : m0_wdata;
          wmask_d = sel ? m1_wmask : m0_wmask;
          rstrb_d = sel ? m1_rstrb : m0_rstrb;
          oor_d   = (sel_addr[31:2] >= C_WORD_LIM);
`ifndef MEM_ARB_FIXED_PRIORITY_EN
          last_d  = sel;
`endif
        end
      end
      S_ISSUE: state_d = S_RESP;
      // Always back to IDLE so a request being withdrawn is never re-sampled.
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      gnt_q   <= 1'b0;
      oor_q   <= 1'b0;
      rstrb_q <= 1'b0;
      wmask_q <= 4'b0;
      addr_q  <= 32'b0;
      wdata_q <= 32'b0;
`ifndef MEM_ARB_FIXED_PRIORITY_EN
      last_q  <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      oor_q   <= oor_d;
      rstrb_q <= rstrb_d;
      wmask_q <= wmask_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
`ifndef MEM_ARB_FIXED_PRIORITY_EN
      last_q  <= last_d;
`endif
    end
  end

  assign in_issue  = (state_q == S_ISSUE);
  assign in_resp   = (state_q == S_RESP);

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wmask = (in_issue & ~oor_q) ? wmask_q : 4'b0;
  assign mem_rstrb = in_issue & ~oor_q & rstrb_q;

  assign resp_data = oor_q ? 32'b0 : mem_rdata;

  assign m0_ack   = in_resp & ~gnt_q;
  assign m1_ack   = in_resp &  gnt_q;
  assign m0_err   = m0_ack & oor_q;
  assign m1_err   = m1_ack & oor_q;
  assign m0_rdata = m0_ack ? resp_data : 32'b0;
  assign m1_rdata = m1_ack ? resp_data : 32'b0;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_arbiter
// Purpose : directed self-checking bench for mem_arbiter with a behavioural RAM.
// Revision: 1.0
// ============================================================================
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_wmask, m1_wmask;
  logic        m0_rstrb, m1_rstrb;
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_ack, m1_ack, m0_err, m1_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;
  logic        mem_rstrb;

  logic [31:0] ram [0:2047];
  logic        pl_we;
  logic [10:0] pl_idx;
  logic [31:0] pl_dat;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.MEM_WORDS(1536)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .m0_addr   (m0_addr),
    .m0_wdata  (m0_wdata),
    .m0_wmask  (m0_wmask),
    .m0_rstrb  (m0_rstrb),
    .m0_rdata  (m0_rdata),
    .m0_ack    (m0_ack),
    .m0_err    (m0_err),
    .m1_addr   (m1_addr),
    .m1_wdata  (m1_wdata),
    .m1_wmask  (m1_wmask),
    .m1_rstrb  (m1_rstrb),
    .m1_rdata  (m1_rdata),
    .m1_ack    (m1_ack),
    .m1_err    (m1_err),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wmask (mem_wmask),
    .mem_rstrb (mem_rstrb),
    .mem_rdata (mem_rdata)
  );

  // Registered-read RAM; 2048 entries so a stray out-of-range write is visible.
  always @(posedge clk) begin
    if (pl_we) ram[pl_idx] <= pl_dat;
    if (mem_rstrb) mem_rdata <= ram[mem_addr[12:2]];
    for (int b = 0; b < 4; b++)
      if (mem_wmask[b]) ram[mem_addr[12:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [10:0] idx, input logic [31:0] dat);
    pl_idx = idx;
    pl_dat = dat;
    pl_we  = 1'b1;
    tick();
    pl_we  = 1'b0;
  endtask

  task automatic drop_all();
    m0_wmask = 4'b0; m0_rstrb = 1'b0;
    m1_wmask = 4'b0; m1_rstrb = 1'b0;
  endtask

  initial begin
    logic e0, e1;
    resetn = 1'b0;
    pl_we = 1'b0; pl_idx = '0; pl_dat = '0;
    mem_rdata = 32'b0;
    m0_addr = '0; m0_wdata = '0; m1_addr = '0; m1_wdata = '0;
    drop_all();

    preload(11'd5,    32'hDEADBEEF);
    preload(11'd8,    32'h11223344);
    preload(11'd16,   32'h00000000);
    preload(11'd1535, 32'hCAFEF00D);
    preload(11'd1536, 32'h00000000);

    chk("rst_acks",  {26'b0, m0_ack, m1_ack, m0_err, m1_err, mem_rstrb, 1'b0}, 32'h0);
    chk("rst_wmask", {28'b0, mem_wmask}, 32'h0);
    chk("rst_addr",  mem_addr, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_rdata", m0_rdata | m1_rdata, 32'h0);
    resetn = 1'b1;

    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle", {26'b0, mem_rstrb, mem_wmask, m0_ack, m1_ack}, 32'h0);
    end

    // Single read by m0
    m0_addr = 32'h14; m0_rstrb = 1'b1;
    tick();
    chk("rd_issue_rstrb", {31'b0, mem_rstrb}, 32'h1);
    chk("rd_issue_addr",  mem_addr, 32'h14);
    chk("rd_issue_ack",   {30'b0, m0_ack, m1_ack}, 32'h0);
    tick();
    chk("rd_ack",   {28'b0, m0_ack, m1_ack, m0_err, mem_rstrb}, 32'h8);
    chk("rd_data",  m0_rdata, 32'hDEADBEEF);
    chk("rd_m1_rdata_zero", m1_rdata, 32'h0);
    drop_all();
    tick();
    chk("rd_after", {30'b0, m0_ack, m1_ack}, 32'h0);
    chk("rd_after_rdata", m0_rdata, 32'h0);

    // Byte write by m1, then read back
    m1_addr = 32'h20; m1_wdata = 32'h000000AA; m1_wmask = 4'b0001;
    tick();
    chk("wr_issue_wmask", {28'b0, mem_wmask}, 32'h1);
    chk("wr_issue_wdata", mem_wdata, 32'hAA);
    chk("wr_issue_rstrb", {31'b0, mem_rstrb}, 32'h0);
    tick();
    chk("wr_ack", {29'b0, m0_ack, m1_ack, m1_err}, 32'h2);
    drop_all();
    tick();
    chk("wr_ack_once", {30'b0, m0_ack, m1_ack}, 32'h0);
    chk("wr_ram", ram[8], 32'h112233AA);
    m1_rstrb = 1'b1;
    tick();
    tick();
    chk("rb_ack", {30'b0, m0_ack, m1_ack}, 32'h1);
    chk("rb_data", m1_rdata, 32'h112233AA);
    drop_all();
    tick();
    chk("rb_ack_once", {31'b0, m1_ack}, 32'h0);

    // Out-of-range write by m0 (word 1536)
    m0_addr = 32'h1800; m0_wdata = 32'hFFFFFFFF; m0_wmask = 4'hF;
    tick();
    chk("oor_issue", {27'b0, mem_rstrb, mem_wmask}, 32'h0);
    tick();
    chk("oor_ack_err", {30'b0, m0_ack, m0_err}, 32'h3);
    chk("oor_rdata", m0_rdata, 32'h0);
    chk("oor_m1", {30'b0, m1_ack, m1_err}, 32'h0);
    drop_all();
    tick();
    chk("oor_ram", ram[1536], 32'h0);

    // Last in-range word (1535) read by m1
    m1_addr = 32'h17FC; m1_rstrb = 1'b1;
    tick();
    chk("edge_rstrb", {31'b0, mem_rstrb}, 32'h1);
    tick();
    chk("edge_ack_err", {30'b0, m1_ack, m1_err}, 32'h2);
    chk("edge_data", m1_rdata, 32'hCAFEF00D);
    drop_all();
    tick();

    // Contention: both masters hold reads from reset
    resetn = 1'b0;
    m0_addr = 32'h14; m0_rstrb = 1'b1;
    m1_addr = 32'h20; m1_rstrb = 1'b1;
    tick();
    tick();
    resetn = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
`ifdef MEM_ARB_FIXED_PRIORITY_EN
      e0 = (k % 3 == 2);
      e1 = 1'b0;
`else
      e0 = (k % 6 == 2);
      e1 = (k % 6 == 5);
`endif
      chk("contend_acks", {30'b0, m0_ack, m1_ack}, {30'b0, e0, e1});
      if (e0) chk("contend_m0_data", m0_rdata, 32'hDEADBEEF);
      if (e1) chk("contend_m1_data", m1_rdata, 32'h112233AA);
    end
    drop_all();

    // Reset during ISSUE of an m1 write
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    m1_addr = 32'h40; m1_wdata = 32'h00000055; m1_wmask = 4'hF;
    tick();
    chk("mid_issue_wmask", {28'b0, mem_wmask}, 32'hF);
    chk("mid_issue_addr",  mem_addr, 32'h40);
    #2;
    resetn = 1'b0;
    #1;
    chk("mid_async_wmask", {28'b0, mem_wmask}, 32'h0);
    chk("mid_async_addr",  mem_addr, 32'h0);
    chk("mid_async_wdata", mem_wdata, 32'h0);
    chk("mid_async_acks",  {30'b0, m0_ack, m1_ack}, 32'h0);
    tick();
    chk("mid_noack", {30'b0, m1_ack, m1_err}, 32'h0);
    chk("mid_ram_untouched", ram[16], 32'h0);
    tick();
    chk("mid_noack2", {31'b0, m1_ack}, 32'h0);
    resetn = 1'b1;
    tick();
    chk("retry_issue", {28'b0, mem_wmask}, 32'hF);
    chk("retry_noack", {31'b0, m1_ack}, 32'h0);
    tick();
    chk("retry_ack", {29'b0, m0_ack, m1_ack, m1_err}, 32'h2);
    drop_all();
    tick();
    chk("retry_ram", ram[16], 32'h55);
    chk("retry_ack_once", {31'b0, m1_ack}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
